// File: rtl/dl_write_queue_if.sv
// Bus bundle between a download/erase byte source and the SDRAM write port.
interface dl_write_queue_if;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        downloading;
    logic        mem_req;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_ack;

    modport master (
        output dl_wr, dl_addr, dl_data, downloading, mem_ack,
        input  mem_req, mem_addr, mem_din
    );

    modport slave (
        input  dl_wr, dl_addr, dl_data, downloading, mem_ack,
        output mem_req, mem_addr, mem_din
    );
endinterface

// File: rtl/dl_write_queue.sv
// Byte write queue: buffers download/erase writes and replays them in order to an SDRAM port.
// Optional macro DL_WQ_CSUM_EN adds an 8-bit running checksum of delivered bytes (csum port).
//
//   state | meaning
//   IDLE  | queue empty, no request outstanding
//   REQ   | mem_req asserted with the head entry, waiting for mem_ack
//   GAP   | one cycle after an ack before the next request is considered
module dl_write_queue #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dl_write_queue_if.slave       bus,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic                  busy
`ifdef DL_WQ_CSUM_EN
    ,
    output logic [7:0]            csum
`endif
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [32:0]           store [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [24:0]           mem_addr_q;
    logic [7:0]            mem_din_q;
    logic                  dl_prev;
    logic                  push, pop, dl_rise, load_head;

    // full comes from the registered count, so a pop this cycle never frees room for a push this cycle
    assign full      = (count == DEPTH_CNT);
    assign push      = bus.dl_wr & ~full;
    assign pop       = (state == REQ) & bus.mem_ack;
    assign dl_rise   = bus.downloading & ~dl_prev;
    assign load_head = (state_next == REQ) && (state != REQ);

    assign bus.mem_req  = (state == REQ);
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign busy         = bus.downloading | (count != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = REQ;
            REQ:     if (bus.mem_ack) state_next = GAP;
            GAP:     state_next = (count != '0) ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) store[wr_ptr] <= {bus.dl_addr, bus.dl_data};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            overflow   <= 1'b0;
            dl_prev    <= 1'b0;
        end else begin
            dl_prev <= bus.downloading;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // head is captured once on entry to REQ and held until the ack
            if (load_head) begin
                mem_addr_q <= store[rd_ptr][32:8];
                mem_din_q  <= store[rd_ptr][7:0];
            end
            // a drop in the same cycle as a new download start still counts
            if (bus.dl_wr && full) overflow <= 1'b1;
            else if (dl_rise)      overflow <= 1'b0;
        end
    end

`ifdef DL_WQ_CSUM_EN
    always_ff @(posedge clk) begin
        if (!reset_n)  csum <= 8'h00;
        else if (dl_rise) csum <= 8'h00;
        else if (pop)  csum <= csum + bus.mem_din;
    end
`endif

endmodule

// File: doc/dl_write_queue.md
DL_WRITE_QUEUE -- requirements
Module: dl_write_queue

Interface
REQ-001 SHALL have parameter: DEPTH_LOG2, default 3, FIFO depth = 2**DEPTH_LOG2 entries (range 1..6).
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port: dl_wr  input  1  one-cycle write strobe from the download/erase source.
REQ-005 SHALL have port: dl_addr  input  25  byte address qualified by dl_wr.
REQ-006 SHALL have port: dl_data  input  8  byte data qualified by dl_wr.
REQ-007 SHALL have port: downloading  input  1  active download/erase indicator from the source.
REQ-008 SHALL have port: mem_req  output  1  write request to the SDRAM port, level.
REQ-009 SHALL have port: mem_addr  output  25  write address, valid while mem_req=1.
REQ-010 SHALL have port: mem_din  output  8  write data, valid while mem_req=1.
REQ-011 SHALL have port: mem_ack  input  1  one-cycle completion pulse from the SDRAM port.
REQ-012 SHALL have port: count  output  DEPTH_LOG2+1  entries held, including the one being presented.
REQ-013 SHALL have port: full  output  1  count == 2**DEPTH_LOG2.
REQ-014 SHALL have port: overflow  output  1  sticky flag, set when a dl_wr is dropped.
REQ-015 SHALL have port: busy  output  1  downloading | (count != 0).

Function
REQ-016 SHALL push {dl_addr,dl_data} when dl_wr=1 and full=0; entry stored at the end of that cycle.
REQ-017 SHALL drop dl_wr when full=1 and set overflow, even when mem_ack pops an entry in the same cycle.
REQ-018 SHALL evaluate full from registered count, so push and pop in the same cycle leave count unchanged when not full.
REQ-019 SHALL implement states IDLE, REQ, GAP; IDLE->REQ when count!=0; REQ->GAP on mem_ack; GAP->REQ if count!=0, else GAP->IDLE; each transition takes one cycle.
REQ-020 SHALL drive mem_req=1 only in REQ, with mem_addr/mem_din held at the FIFO head and stable until mem_ack.
REQ-021 SHALL pop the head and decrement count in the cycle mem_ack=1 while in REQ; mem_ack outside REQ SHALL be ignored.
REQ-022 SHALL give latency from dl_wr in cycle N, with the queue empty and in IDLE, to mem_req=1 in cycle N+2.
REQ-023 SHALL wrap read and write pointers modulo 2**DEPTH_LOG2 with no lost or duplicated entries.
REQ-024 SHALL preserve write order exactly; no merging or reordering.
REQ-025 SHALL clear overflow on a rising edge of downloading (registered compare with previous value).

Reset
REQ-026 SHALL, with reset_n=0, set after the edge: state=IDLE, pointers=0, count=0, mem_req=0, mem_addr=0, mem_din=0, full=0, overflow=0.
REQ-027 SHALL, with reset asserted mid-request, discard all queued entries and deassert mem_req on the next edge; later mem_ack SHALL be ignored.

Configuration
REQ-028 SHALL, with DL_WQ_CSUM_EN defined, add output csum (8 bit, reset 0): the modulo-256 sum of mem_din over every popped entry, cleared on a rising edge of downloading.
REQ-029 SHALL, without DL_WQ_CSUM_EN, omit the csum port and all checksum logic.

Verification
REQ-030 SHALL cover single write: dl_wr at N with addr 0x200000, data 0xA5, ack 3 cycles after req -> mem_req at N+2 showing 0x200000/0xA5, count 1->0, busy tracks downloading.
REQ-031 SHALL cover fill with DEPTH_LOG2=3 and no ack: 9 writes -> full=1 after the 8th, 9th dropped, overflow=1; then 8 acks -> data emerges in order, count 0.
REQ-032 SHALL cover simultaneous push/pop at count 4 -> count stays 4, order intact.
REQ-033 SHALL cover wrap-around: 20 writes, data 0x00..0x13, immediate acks -> all 20 delivered in order with no drops.
REQ-034 SHALL cover reset mid-REQ with count 5 -> mem_req 0 and count 0 next cycle; stray mem_ack causes no pop.
REQ-035 SHALL cover DL_WQ_CSUM_EN: bytes 0x80, 0x90, 0x10 -> csum 0x20; downloading rising edge -> csum 0, overflow 0.
